// File: rtl/ysyx_24100027_mdu.sv
// rtl/ysyx_24100027_mdu.sv - iterative RV32M multiply/divide unit, one bit per cycle
module ysyx_24100027_mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic        sign_a_q;
    logic [31:0] opnd_q;     // multiplicand for MUL*, divisor for DIV*/REM*
    logic [63:0] acc_q;      // product, or {remainder, dividend/quotient}
    logic [31:0] result_q;

    // request decode: signedness, magnitudes, special divides
    logic        accept;
    logic        sgn_a, sgn_b;
    logic [31:0] abs_a, abs_b;
    logic        div_zero, div_ovf, special;
    logic [31:0] special_res;

    assign accept   = in_valid & (state_q == S_IDLE) & ~flush;
    assign sgn_a    = a[31] & ((op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110));
    assign sgn_b    = b[31] & ((op == 3'b001) | (op == 3'b100) | (op == 3'b110));
    assign abs_a    = sgn_a ? -a : a;
    assign abs_b    = sgn_b ? -b : b;
    assign div_zero = op[2] & (b == 32'd0);
    assign div_ovf  = ((op == 3'b100) | (op == 3'b110)) & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    assign special  = div_zero | div_ovf;
    assign special_res = div_zero ? (op[1] ? a : 32'hFFFF_FFFF)
                                  : (op[1] ? 32'd0 : 32'h8000_0000);

    // one iteration of shift-add multiply and restoring divide
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] iter_next;

    assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    assign mul_next  = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[31:0] - opnd_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};
    assign iter_next = op_q[2] ? div_next : mul_next;

    // sign fix-up applied to the value produced by the last iteration
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] final_res;

    assign prod_fix = neg_q ? -mul_next : mul_next;
    assign quo_fix  = neg_q ? -div_next[31:0] : div_next[31:0];
    assign rem_fix  = sign_a_q ? -div_next[63:32] : div_next[63:32];

    // select the architectural result for the captured opcode
    always_comb begin
        final_res = rem_fix;
        case (op_q)
            3'b000:                 final_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // outputs decoded from state only, no input-to-output paths
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        result    = result_q;
    end

    // datapath: operand capture on accept, iterate in CALC, load result at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
        end else if (accept) begin
            cnt_q    <= 5'd0;
            op_q     <= op;
            neg_q    <= sgn_a ^ sgn_b;
            sign_a_q <= sgn_a;
            opnd_q   <= op[2] ? abs_b : abs_a;
            acc_q    <= {32'd0, (op[2] ? abs_a : abs_b)};
            if (special) result_q <= special_res;
        end else if (state_q == S_CALC && !flush) begin
            acc_q <= iter_next;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) result_q <= final_res;
        end
    end

endmodule

// File: tb/tb_ysyx_24100027_mdu.sv
// tb/tb_ysyx_24100027_mdu.sv - directed vector bench for ysyx_24100027_mdu
module tb_ysyx_24100027_mdu;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_24100027_mdu dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp, input int lat);
        int k;
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        in_valid = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check({name, " latency"}, k, lat);
        check({name, " result"}, result, exp);
        @(posedge clk); #1;
        check({name, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        int seen;

        vecs[0]  = '{"MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{"MULH 7*-3",       3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vecs[2]  = '{"MULHU 7*fffffffd",3'b011, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 33};
        vecs[3]  = '{"DIV -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[4]  = '{"REM -7%2",        3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[5]  = '{"DIVU 100/7",      3'b101, 32'd100,        32'd7,         32'd14,        33};
        vecs[6]  = '{"REMU 100%7",      3'b111, 32'd100,        32'd7,         32'd2,         33};
        vecs[7]  = '{"DIVU 5/0",        3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[8]  = '{"REM 5%0",         3'b110, 32'd5,          32'd0,         32'd5,         1};
        vecs[9]  = '{"DIV ovf",         3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[10] = '{"REM ovf",         3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[11] = '{"DIV 7/-2",        3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[12] = '{"REM 7%-2",        3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vecs[13] = '{"MULH min*min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready",  {31'd0, in_ready},  32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset result",    result,             32'd0);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // consumer stall: result and in_ready must hold while out_ready is low
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b010; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            @(posedge clk); #1; seen++;
        end
        check("MULHSU stall result", result, 32'hFFFF_FFFF);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (result !== 32'hFFFF_FFFF || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("stall hold cycles bad", bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall release in_ready",  {31'd0, in_ready},  32'd1);
        check("stall release out_valid", {31'd0, out_valid}, 32'd0);

        // flush at CALC iteration 15
        in_valid = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready",  {31'd0, in_ready},  32'd1);
        check("flush busy",      {31'd0, busy},      32'd0);
        check("flush result kept", result,           32'hFFFF_FFFF);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush out_valid rises", seen, 0);
        run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // in_valid held through CALC, then reset mid-operation
        in_valid = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check("held in_valid second accept", bad, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("mid reset in_ready",  {31'd0, in_ready},  32'd1);
        check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid reset busy",      {31'd0, busy},      32'd0);
        check("mid reset result",    result,             32'd0);
        run_op("DIVU 100/7 after reset", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
